// File: rtl/cmul_sched_pkg.sv
// Shared types and the per-product schedule for the complex-multiply sequencer.
package cmul_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef logic [1:0] prod_idx_t;

    // Bit k of each mask describes partial product k: ar*br, ai*bi, ar*bi, ai*br.
    localparam logic [3:0] SEL_A_IMAG = 4'b1010;
    localparam logic [3:0] SEL_B_IMAG = 4'b0110;
    localparam logic [3:0] NEGATE     = 4'b0010;
    localparam logic [3:0] DEST_IM    = 4'b1100;

endpackage

// File: rtl/cmul_accum.sv
// Return counter and re/im accumulators fed by the shared multiplier's results.
module cmul_accum
    import cmul_sched_pkg::*;
#(
    parameter int P_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      clear,
    input  logic                      collect,
    input  logic signed [P_WIDTH-1:0] mul_C,
    input  logic                      mul_out_valid,
    output logic signed [P_WIDTH:0]   acc_re,
    output logic signed [P_WIDTH:0]   acc_im,
    output logic                      full,
    output logic                      last_capture,
    output logic                      stray
);

    prod_idx_t               r;
    logic                    capture;
    logic signed [P_WIDTH:0] product_ext;

    assign capture      = mul_out_valid && collect && !full;
    assign last_capture = capture && (r == 2'd3);
    assign stray        = mul_out_valid && !capture;
    assign product_ext  = {mul_C[P_WIDTH-1], mul_C};

    // Results come back in issue order, so the return index alone picks the destination.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r      <= '0;
            full   <= 1'b0;
            acc_re <= '0;
            acc_im <= '0;
        end else if (clear) begin
            r      <= '0;
            full   <= 1'b0;
            acc_re <= '0;
            acc_im <= '0;
        end else if (capture) begin
            if (DEST_IM[r]) begin
                acc_im <= acc_im + product_ext;
            end else begin
                acc_re <= acc_re + product_ext;
            end
            r <= r + 2'd1;
            if (r == 2'd3) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmul_sched.sv
// Runs one complex multiply by issuing its four partial products to a shared real multiplier.
module cmul_sched
    import cmul_sched_pkg::*;
#(
    parameter int A_WIDTH = 6,
    parameter int B_WIDTH = 6
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [A_WIDTH-1:0]         in_ar,
    input  logic signed [A_WIDTH-1:0]         in_ai,
    input  logic signed [B_WIDTH-1:0]         in_br,
    input  logic signed [B_WIDTH-1:0]         in_bi,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [A_WIDTH+B_WIDTH:0]   out_re,
    output logic signed [A_WIDTH+B_WIDTH:0]   out_im,
    output logic                              err,
    output logic                              mul_valid,
    output logic signed [A_WIDTH-1:0]         mul_A,
    output logic signed [B_WIDTH-1:0]         mul_B,
    output logic                              mul_both_image,
    input  logic signed [A_WIDTH+B_WIDTH-1:0] mul_C,
    input  logic                              mul_out_valid
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    state_t                    state;
    prod_idx_t                 k;
    prod_idx_t                 next_k;
    logic signed [A_WIDTH-1:0] ar_q, ai_q;
    logic signed [B_WIDTH-1:0] br_q, bi_q;
    logic signed [A_WIDTH-1:0] next_a;
    logic signed [B_WIDTH-1:0] next_b;
    logic                      accept;
    logic                      collect;
    logic                      full;
    logic                      last_capture;
    logic                      stray;

    assign in_ready = (state == IDLE);
    assign accept   = (state == IDLE) && in_valid;
    assign collect  = (state == ISSUE) || (state == WAIT);

    always_comb begin
        next_k = k + 2'd1;
        next_a = SEL_A_IMAG[next_k] ? ai_q : ar_q;
        next_b = SEL_B_IMAG[next_k] ? bi_q : br_q;
    end

    cmul_accum #(
        .P_WIDTH (P_WIDTH)
    ) u_accum (
        .clk           (clk),
        .resetn        (resetn),
        .clear         (accept),
        .collect       (collect),
        .mul_C         (mul_C),
        .mul_out_valid (mul_out_valid),
        .acc_re        (out_re),
        .acc_im        (out_im),
        .full          (full),
        .last_capture  (last_capture),
        .stray         (stray)
    );

    // Product 0 is issued straight from the input bus on the accept edge; the rest come from the captured copies.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            k              <= '0;
            ar_q           <= '0;
            ai_q           <= '0;
            br_q           <= '0;
            bi_q           <= '0;
            out_valid      <= 1'b0;
            mul_valid      <= 1'b0;
            mul_A          <= '0;
            mul_B          <= '0;
            mul_both_image <= 1'b0;
            err            <= 1'b0;
        end else begin
            err <= err | stray;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ar_q           <= in_ar;
                        ai_q           <= in_ai;
                        br_q           <= in_br;
                        bi_q           <= in_bi;
                        k              <= '0;
                        mul_valid      <= 1'b1;
                        mul_A          <= SEL_A_IMAG[0] ? in_ai : in_ar;
                        mul_B          <= SEL_B_IMAG[0] ? in_bi : in_br;
                        mul_both_image <= NEGATE[0];
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (k == 2'd3) begin
                        mul_valid      <= 1'b0;
                        mul_A          <= '0;
                        mul_B          <= '0;
                        mul_both_image <= 1'b0;
                        state          <= WAIT;
                    end else begin
                        k              <= next_k;
                        mul_A          <= next_a;
                        mul_B          <= next_b;
                        mul_both_image <= NEGATE[next_k];
                    end
                end
                WAIT: begin
                    if (last_capture || full) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmul_sched.sv
// Bench for cmul_sched: delayed multiplier model, cycle-level expectation model, directed vectors.
module tb_cmul_sched;

    localparam int AW   = 6;
    localparam int BW   = 6;
    localparam int PW   = AW + BW;
    localparam int RW   = PW + 1;
    localparam int MAXL = 8;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [AW-1:0] in_ar = '0;
    logic signed [AW-1:0] in_ai = '0;
    logic signed [BW-1:0] in_br = '0;
    logic signed [BW-1:0] in_bi = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [RW-1:0] out_re;
    logic signed [RW-1:0] out_im;
    logic                 err;
    logic                 mul_valid;
    logic signed [AW-1:0] mul_A;
    logic signed [BW-1:0] mul_B;
    logic                 mul_both_image;
    logic signed [PW-1:0] mul_C;
    logic                 mul_out_valid;

    int checks   = 0;
    int failures = 0;
    int lat      = 2;
    logic [2:0] lat_idx;

    logic                 pipe_v [MAXL] = '{default: 1'b0};
    logic signed [PW-1:0] pipe_c [MAXL] = '{default: '0};
    logic                 inj_v = 1'b0;
    logic signed [PW-1:0] inj_c = '0;

    cmul_sched #(
        .A_WIDTH (AW),
        .B_WIDTH (BW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ar          (in_ar),
        .in_ai          (in_ai),
        .in_br          (in_br),
        .in_bi          (in_bi),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_re         (out_re),
        .out_im         (out_im),
        .err            (err),
        .mul_valid      (mul_valid),
        .mul_A          (mul_A),
        .mul_B          (mul_B),
        .mul_both_image (mul_both_image),
        .mul_C          (mul_C),
        .mul_out_valid  (mul_out_valid)
    );

    always #5 clk = ~clk;

    // multiply_image stand-in: fixed latency, negated product on both_image, no reset of its own.
    assign lat_idx       = 3'(lat - 1);
    assign mul_out_valid = inj_v | pipe_v[lat_idx];
    assign mul_C         = inj_v ? inj_c : pipe_c[lat_idx];

    always @(posedge clk) begin
        pipe_v[0] <= mul_valid;
        pipe_c[0] <= mul_both_image ? PW'(-(int'(mul_A) * int'(mul_B)))
                                    : PW'(int'(mul_A) * int'(mul_B));
        for (int i = 1; i < MAXL; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_c[i] <= pipe_c[i-1];
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Expectation model: one operation in flight, timed from the accept edge.
    int cyc = 0;
    int t0 = 0;
    int nres = 0;
    bit busy = 1'b0;
    bit err_m = 1'b0;
    int m_ar = 0, m_ai = 0, m_br = 0, m_bi = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy  = 1'b0;
            nres  = 0;
            err_m = 1'b0;
        end else begin
            cyc++;
            if (mul_out_valid) begin
                if (busy && nres < 4) nres++;
                else err_m = 1'b1;
            end
            if (busy) begin
                if (cyc - t0 >= 5 + lat && out_ready) busy = 1'b0;
            end else if (in_valid) begin
                busy = 1'b1;
                t0   = cyc;
                nres = 0;
                m_ar = int'(in_ar);
                m_ai = int'(in_ai);
                m_br = int'(in_br);
                m_bi = int'(in_bi);
            end
        end
    end

    always @(negedge clk) begin : compare
        int rel;
        int kk;
        bit emv;
        bit eov;
        if (!resetn) begin
            checkOutput("rst_in_ready", int'(in_ready), 1);
            checkOutput("rst_out_valid", int'(out_valid), 0);
            checkOutput("rst_mul_valid", int'(mul_valid), 0);
            checkOutput("rst_mul_A", int'(mul_A), 0);
            checkOutput("rst_mul_B", int'(mul_B), 0);
            checkOutput("rst_both_image", int'(mul_both_image), 0);
            checkOutput("rst_err", int'(err), 0);
            checkOutput("rst_out_re", int'(out_re), 0);
            checkOutput("rst_out_im", int'(out_im), 0);
        end else begin
            rel = cyc - t0 + 1;
            kk  = rel - 1;
            emv = busy && rel >= 1 && rel <= 4;
            eov = busy && rel >= 5 + lat;
            checkOutput("in_ready", int'(in_ready), busy ? 0 : 1);
            checkOutput("mul_valid", int'(mul_valid), int'(emv));
            checkOutput("mul_A", int'(mul_A), emv ? ((kk == 1 || kk == 3) ? m_ai : m_ar) : 0);
            checkOutput("mul_B", int'(mul_B), emv ? ((kk == 1 || kk == 2) ? m_bi : m_br) : 0);
            checkOutput("mul_both_image", int'(mul_both_image), (emv && kk == 1) ? 1 : 0);
            checkOutput("out_valid", int'(out_valid), int'(eov));
            checkOutput("err", int'(err), int'(err_m));
            if (eov) begin
                checkOutput("out_re", int'(out_re), m_ar * m_br - m_ai * m_bi);
                checkOutput("out_im", int'(out_im), m_ar * m_bi + m_ai * m_br);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ar, input int ai, input int br, input int bi,
                                 output int waited);
        in_ar    = AW'(ar);
        in_ai    = AW'(ai);
        in_br    = BW'(br);
        in_bi    = BW'(bi);
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int n);
        n = 1;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        if (!out_valid) checkOutput("result_timeout", 0, 1);
    endtask

    task automatic runOp(input string name, input int ar, input int ai, input int br,
                         input int bi, input int exp_re, input int exp_im, input int exp_lat);
        int w;
        int n;
        applyStimulus(ar, ai, br, bi, w);
        waitResult(n);
        checkOutput({name, "_re"}, int'(out_re), exp_re);
        checkOutput({name, "_im"}, int'(out_im), exp_im);
        checkOutput({name, "_latency"}, n, exp_lat);
        tick();
    endtask

    initial begin
        int w;
        int n;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("init_in_ready", int'(in_ready), 1);
        checkOutput("init_out_valid", int'(out_valid), 0);
        checkOutput("init_err", int'(err), 0);
        resetn = 1'b1;
        repeat (2) tick();

        runOp("basic", 3, 2, 1, 4, -5, 14, 7);
        runOp("corner_min", -32, -32, -32, -32, 0, 2048, 7);
        runOp("corner_mix", -32, 31, 31, -32, 0, 1985, 7);

        // Back-pressure, then a second operation accepted one edge after the handshake.
        out_ready = 1'b0;
        applyStimulus(7, -3, -5, 6, w);
        waitResult(n);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bp_out_valid", int'(out_valid), 1);
            checkOutput("bp_re", int'(out_re), -17);
            checkOutput("bp_im", int'(out_im), 57);
            checkOutput("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        applyStimulus(2, 1, -1, 3, w);
        checkOutput("bp_next_accept_wait", w, 1);
        waitResult(n);
        checkOutput("bp_next_re", int'(out_re), -5);
        checkOutput("bp_next_im", int'(out_im), 5);
        tick();

        // Stray multiplier result while idle.
        repeat (3) tick();
        inj_c = PW'(100);
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        checkOutput("stray_err", int'(err), 1);
        repeat (3) tick();
        checkOutput("stray_err_sticky", int'(err), 1);
        runOp("after_stray", 4, -5, -2, 3, 7, 22, 7);

        repeat (10) tick();
        lat = 1;
        runOp("lat1", 5, -7, -3, 2, -1, 31, 6);
        repeat (10) tick();
        lat = 6;
        runOp("lat6", -20, 13, 17, 9, -457, 41, 11);
        repeat (10) tick();
        lat = 2;

        // Reset three cycles into an operation; results still in flight must flag err.
        applyStimulus(3, 2, 1, 4, w);
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        checkOutput("midrst_mul_valid", int'(mul_valid), 0);
        checkOutput("midrst_mul_A", int'(mul_A), 0);
        checkOutput("midrst_in_ready", int'(in_ready), 1);
        checkOutput("midrst_err", int'(err), 0);
        @(negedge clk);
        #1 resetn = 1'b1;
        tick();
        checkOutput("inflight_err", int'(err), 1);
        repeat (10) tick();
        runOp("after_reset", -32, 31, 31, -32, 0, 1985, 7);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
